// File: rtl/risc_pkg.sv
// Shared defaults for the register file and helpers for the flat per-port read buses.
package risc_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 5;
  localparam int unsigned DefNRead = 2;

  // Lowest bit of read port `port` in a bus packing `width` bits per port.
  function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

  function automatic int unsigned nreg(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-destination scoreboard: one bit per register, reservation accept logic and a
// registered population count kept incrementally.
module reg_scoreboard
  import risc_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic                   rsv_en,
  input  logic [ADDR_W-1:0]      rsv_addr,
  output logic                   rsv_ok,
  output logic [2**ADDR_W-1:0]   pend,
  output logic [ADDR_W:0]        pend_cnt
);

  localparam int unsigned NReg = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CntOne = 1;

  logic [NReg-1:0] pend_q, pend_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic            wr_hit, same_addr, cnt_inc, cnt_dec;

  always_comb begin
    wr_hit    = wr_en && (wr_addr != '0);
    rsv_ok    = rsv_en && (rsv_addr != '0) &&
                (!pend_q[rsv_addr] || (wr_en && (wr_addr == rsv_addr)));
    same_addr = wr_hit && rsv_ok && (wr_addr == rsv_addr);

    pend_d = pend_q;
    if (wr_hit) pend_d[wr_addr] = 1'b0;
    if (rsv_ok) pend_d[rsv_addr] = 1'b1;

    // A same-address clear is overridden by the set, so it never decrements.
    cnt_inc = rsv_ok && !pend_q[rsv_addr];
    cnt_dec = wr_hit && pend_q[wr_addr] && !same_addr;

    cnt_d = cnt_q;
    if (cnt_inc && !cnt_dec) begin
      cnt_d = cnt_q + CntOne;
    end else if (cnt_dec && !cnt_inc) begin
      cnt_d = cnt_q - CntOne;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend     = pend_q;
  assign pend_cnt = cnt_q;

  assert property (@(posedge clk) disable iff (rst) !pend_q[0]);
  assert property (@(posedge clk) disable iff (rst) int'(cnt_q) == $countones(pend_q));

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with write-through bypass and a pending-destination
// scoreboard. Register 0 is hardwired to zero and can never be reserved.
module reg_file_sb
  import risc_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned NREAD  = DefNRead
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREAD-1:0]          rd_en,
  input  logic [NREAD*ADDR_W-1:0]   rd_addr,
  output logic [NREAD*DATA_W-1:0]   rd_data,
  output logic [NREAD-1:0]          rd_busy,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic                      rsv_en,
  input  logic [ADDR_W-1:0]         rsv_addr,
  output logic                      rsv_ok,
  output logic [ADDR_W:0]           pend_cnt
);

  localparam int unsigned NReg = nreg(ADDR_W);

  logic [DATA_W-1:0] mem_q [NReg];
  logic [NReg-1:0]   pend;
  logic              wr_hit;

  assign wr_hit = wr_en && (wr_addr != '0);

  reg_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ok   (rsv_ok),
    .pend     (pend),
    .pend_cnt (pend_cnt)
  );

  // Entry 0 is only ever reset, so it reads as zero without a separate mux leg.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NReg); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_hit) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < int'(NREAD); p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              bypass;
    logic [DATA_W-1:0] data_d, data_q;
    logic              busy_d, busy_q;

    assign addr = rd_addr[port_lsb(p, ADDR_W) +: ADDR_W];

    always_comb begin
      bypass = wr_hit && (wr_addr == addr);
      data_d = mem_q[addr];
      busy_d = pend[addr];
      if (bypass) begin
        // The write clears the pending bit unless this edge's reservation re-arms it.
        data_d = wr_data;
        busy_d = rsv_ok && (rsv_addr == addr);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q <= '0;
        busy_q <= 1'b0;
      end else if (rd_en[p]) begin
        data_q <= data_d;
        busy_q <= busy_d;
      end
    end

    assign rd_data[port_lsb(p, DATA_W) +: DATA_W] = data_q;
    assign rd_busy[p] = busy_q;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb with hand-computed expectations.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        rsv_ok;
  logic [5:0]  pend_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  reg_file_sb dut (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rsv_ok   (rsv_ok),
    .pend_cnt (pend_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle();
    rd_en  = 2'b00;
    wr_en  = 1'b0;
    rsv_en = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic do_rsv(input logic [4:0] a);
    rsv_en   = 1'b1;
    rsv_addr = a;
  endtask

  task automatic do_read(input logic [1:0] en, input logic [4:0] a1, input logic [4:0] a0);
    rd_en   = en;
    rd_addr = {a1, a0};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle();
    rd_addr = '0; wr_addr = '0; wr_data = '0; rsv_addr = '0;
    #3;
    check("rst_data", rd_data, 64'h0);
    check("rst_busy", rd_busy, 2'b00);
    check("rst_cnt",  pend_cnt, 6'd0);

    @(negedge clk);
    rst = 1'b0;

    // Sweep every address after reset.
    for (int a = 0; a < 32; a++) begin
      do_read(2'b01, 5'd0, 5'(a));
      tick();
      check($sformatf("sweep_data_%0d", a), rd_data[31:0], 32'h0);
      check($sformatf("sweep_busy_%0d", a), rd_busy[0], 1'b0);
      check($sformatf("sweep_cnt_%0d", a), pend_cnt, 6'd0);
    end

    // Plain write then dual-port read.
    idle(); do_write(5'd5, 32'hDEADBEEF);
    tick();
    idle(); do_read(2'b11, 5'd5, 5'd5);
    tick();
    check("r5_p0", rd_data[31:0], 32'hDEADBEEF);
    check("r5_p1", rd_data[63:32], 32'hDEADBEEF);
    check("r5_busy", rd_busy, 2'b00);

    // rd_en low holds the last data.
    idle(); do_read(2'b00, 5'd1, 5'd1);
    tick();
    check("hold_p0", rd_data[31:0], 32'hDEADBEEF);

    // Same-edge write and read on port 1 bypasses; port 0 reads stored r5.
    idle(); do_write(5'd7, 32'h12345678); do_read(2'b11, 5'd7, 5'd5);
    tick();
    check("bypass_p1", rd_data[63:32], 32'h12345678);
    check("bypass_p0", rd_data[31:0], 32'hDEADBEEF);
    check("bypass_busy", rd_busy[1], 1'b0);

    // Reservation of r3, duplicate rejected, busy read, then release by write.
    idle(); do_rsv(5'd3);
    #1 check("rsv3_ok", rsv_ok, 1'b1);
    tick();
    check("rsv3_cnt", pend_cnt, 6'd1);
    #1 check("rsv3_again_ok", rsv_ok, 1'b0);
    tick();
    check("rsv3_again_cnt", pend_cnt, 6'd1);
    idle(); do_read(2'b01, 5'd0, 5'd3);
    tick();
    check("r3_busy", rd_busy[0], 1'b1);
    check("r3_data_old", rd_data[31:0], 32'h0);
    idle(); do_write(5'd3, 32'h55);
    tick();
    check("r3_wr_cnt", pend_cnt, 6'd0);
    idle(); do_read(2'b01, 5'd0, 5'd3);
    tick();
    check("r3_busy_clr", rd_busy[0], 1'b0);
    check("r3_data", rd_data[31:0], 32'h55);

    // Register 0 ignores writes and reservations; no bypass for address 0.
    idle(); do_write(5'd0, 32'hFFFFFFFF); do_rsv(5'd0); do_read(2'b01, 5'd0, 5'd0);
    #1 check("r0_rsv_ok", rsv_ok, 1'b0);
    tick();
    check("r0_bypass", rd_data[31:0], 32'h0);
    check("r0_cnt", pend_cnt, 6'd0);
    idle(); do_read(2'b01, 5'd0, 5'd0);
    tick();
    check("r0_data", rd_data[31:0], 32'h0);
    check("r0_busy", rd_busy[0], 1'b0);

    // r9: reserve, then write + re-reserve + read on one edge.
    idle(); do_rsv(5'd9);
    tick();
    check("r9_cnt", pend_cnt, 6'd1);
    idle(); do_write(5'd9, 32'hA); do_rsv(5'd9); do_read(2'b01, 5'd0, 5'd9);
    #1 check("r9_rerv_ok", rsv_ok, 1'b1);
    tick();
    check("r9_rerv_cnt", pend_cnt, 6'd1);
    check("r9_data", rd_data[31:0], 32'hA);
    check("r9_busy", rd_busy[0], 1'b1);

    // Set and clear of different registers on one edge nets to no change.
    idle(); do_rsv(5'd4);
    tick();
    check("r4_cnt", pend_cnt, 6'd2);
    idle(); do_write(5'd9, 32'hB); do_rsv(5'd6);
    tick();
    check("mix_cnt", pend_cnt, 6'd2);
    idle(); do_read(2'b11, 5'd9, 5'd6);
    tick();
    check("mix_busy", rd_busy, 2'b01);
    check("mix_r9", rd_data[63:32], 32'hB);

    // Asynchronous reset mid-operation discards the pending write and reservation.
    idle(); do_write(5'd12, 32'h77); do_rsv(5'd10); do_read(2'b11, 5'd12, 5'd12);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_data", rd_data, 64'h0);
    check("arst_busy", rd_busy, 2'b00);
    check("arst_cnt", pend_cnt, 6'd0);
    tick();
    check("arst_edge_cnt", pend_cnt, 6'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(); do_write(5'd11, 32'h77); do_rsv(5'd4); do_read(2'b11, 5'd12, 5'd11);
    #1 check("post_rsv_ok", rsv_ok, 1'b1);
    tick();
    check("post_bypass", rd_data[31:0], 32'h77);
    check("post_r12", rd_data[63:32], 32'h0);
    check("post_cnt", pend_cnt, 6'd1);
    idle(); do_read(2'b11, 5'd9, 5'd4);
    tick();
    check("post_busy", rd_busy, 2'b01);
    check("post_r9", rd_data[63:32], 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
